// File: rtl/oit_req_enc_pkg.sv
// Shared types and width helper for the sequential request encoder.
package oit_req_enc_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } oit_req_enc_state_t;

    // Bits needed to address indices 0..n-1, never less than one.
    function automatic int oitBits(input int n);
        int b;
        b = 1;
        while ((1 << b) < n) begin
            b++;
        end
        return b;
    endfunction

    localparam int OIT_REQ_ENC_COUNT_DEFAULT = 8;
    localparam int OIT_REQ_ENC_IDXW_DEFAULT  = oitBits(OIT_REQ_ENC_COUNT_DEFAULT);

endpackage

// File: rtl/oit_prio_encoder.sv
// Combinational lowest-set-bit encoder with any/single-bit flags.
module oit_prio_encoder
    import oit_req_enc_pkg::*;
#(
    parameter  int COUNT = 8,
    localparam int IDXW  = oitBits(COUNT)
) (
    input  logic [COUNT-1:0] req_vec,
    output logic [IDXW-1:0]  idx,
    output logic             any,
    output logic             onehot_single
);

    // Scan downward so the lowest asserted line wins; only 0..COUNT-1 is reachable.
    always_comb begin
        idx = '0;
        for (int i = COUNT - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                idx = IDXW'(i);
            end
        end
    end

    assign any           = |req_vec;
    assign onehot_single = any & ~(|(req_vec & (req_vec - COUNT'(1))));

endmodule

// File: rtl/oit_req_encoder.sv
// Sequential request encoder: emits the index of each pending line, lowest first.
// Optional build macro OIT_REQ_ENC_MERGE_EN: accept and OR-merge loads while emitting.
module oit_req_encoder
    import oit_req_enc_pkg::*;
#(
    parameter  int COUNT  = 8,
    parameter  int ACTIVE = 1,
    localparam int IDXW   = oitBits(COUNT)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [COUNT-1:0] req_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [IDXW-1:0]  idx_out,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic             last,
    output logic             done
);

    oit_req_enc_state_t state, state_nxt;

    logic [COUNT-1:0] pending;
    logic [COUNT-1:0] pend_in;
    logic [COUNT-1:0] pend_cleared;
    logic [COUNT-1:0] pend_nxt;
    logic [IDXW-1:0]  nxt_idx;
    logic             nxt_any;
    logic             nxt_single;
    logic             load_fire;
    logic             hs;
    logic             idx_upd;
    logic             done_nxt;

    assign pend_in   = (ACTIVE != 0) ? req_in : ~req_in;
    assign idx_valid = (state == EMIT);

`ifdef OIT_REQ_ENC_MERGE_EN
    assign load_ready = reset;
`else
    assign load_ready = reset & (state == IDLE);
`endif

    assign load_fire = load_valid & load_ready;
    assign hs        = idx_valid & idx_ready;

    // The served bit is cleared before any merge, so a re-request is emitted again.
    // pending is zero in IDLE, so one expression covers load and merge.
    assign pend_cleared = hs ? (pending & ~(COUNT'(1) << idx_out)) : pending;
    assign pend_nxt     = pend_cleared | (load_fire ? pend_in : '0);

    oit_prio_encoder #(
        .COUNT(COUNT)
    ) u_enc (
        .req_vec      (pend_nxt),
        .idx          (nxt_idx),
        .any          (nxt_any),
        .onehot_single(nxt_single)
    );

    always_comb begin
        state_nxt = state;
        idx_upd   = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (load_fire && nxt_any) begin
                    state_nxt = EMIT;
                    idx_upd   = 1'b1;
                end
            end
            EMIT: begin
                if (hs) begin
                    idx_upd = 1'b1;
                    if (!nxt_any) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            idx_out <= '0;
            last    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pend_nxt;
            if (idx_upd) begin
                idx_out <= nxt_idx;
            end
            last <= (state_nxt == EMIT) & nxt_single;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_oit_req_encoder.sv
// Scoreboard bench for oit_req_encoder: COUNT=8/ACTIVE=1, COUNT=8/ACTIVE=0, COUNT=5/ACTIVE=1.
module tb_oit_req_encoder;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0] req_a, req_b;
    logic [4:0] req_c;
    logic       lv_a, lr_a, iv_a, ir_a, last_a, done_a;
    logic       lv_b, lr_b, iv_b, ir_b, last_b, done_b;
    logic       lv_c, lr_c, iv_c, ir_c, last_c, done_c;
    logic [2:0] idx_a, idx_b, idx_c;

    oit_req_encoder #(.COUNT(8), .ACTIVE(1)) u_dut_a (
        .clock(clock), .reset(reset), .req_in(req_a), .load_valid(lv_a), .load_ready(lr_a),
        .idx_out(idx_a), .idx_valid(iv_a), .idx_ready(ir_a), .last(last_a), .done(done_a)
    );
    oit_req_encoder #(.COUNT(8), .ACTIVE(0)) u_dut_b (
        .clock(clock), .reset(reset), .req_in(req_b), .load_valid(lv_b), .load_ready(lr_b),
        .idx_out(idx_b), .idx_valid(iv_b), .idx_ready(ir_b), .last(last_b), .done(done_b)
    );
    oit_req_encoder #(.COUNT(5), .ACTIVE(1)) u_dut_c (
        .clock(clock), .reset(reset), .req_in(req_c), .load_valid(lv_c), .load_ready(lr_c),
        .idx_out(idx_c), .idx_valid(iv_c), .idx_ready(ir_c), .last(last_c), .done(done_c)
    );

    typedef struct packed {
        logic [2:0] idx;
        logic       lst;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    logic exp_done_a = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input int which, input int idx, input bit lst);
        exp_t e;
        e.idx = idx[2:0];
        e.lst = lst;
        case (which)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while ((q_a.size() + q_b.size() + q_c.size()) != 0 && k < bound) begin
            cyc();
            k++;
        end
        chk("drain_left", q_a.size() + q_b.size() + q_c.size(), 0);
        cyc(2);
    endtask

    // Monitor A also checks that done pulses exactly one cycle after the final handshake.
    always @(negedge clock) begin : mon_a
        exp_t e;
        if (reset) begin
            if (done_a || exp_done_a) chk("done_a", done_a, exp_done_a);
            exp_done_a <= 1'b0;
            if (iv_a && ir_a) begin
                if (q_a.size() == 0) begin
                    chk("unexpected_idx_a", idx_a, 32'hFFFF_FFFF);
                end else begin
                    e = q_a.pop_front();
                    chk("idx_a", idx_a, e.idx);
                    chk("last_a", last_a, e.lst);
                    exp_done_a <= e.lst;
                end
            end
        end else begin
            exp_done_a <= 1'b0;
        end
    end

    always @(negedge clock) begin : mon_b
        exp_t e;
        if (reset && iv_b && ir_b) begin
            if (q_b.size() == 0) begin
                chk("unexpected_idx_b", idx_b, 32'hFFFF_FFFF);
            end else begin
                e = q_b.pop_front();
                chk("idx_b", idx_b, e.idx);
                chk("last_b", last_b, e.lst);
            end
        end
    end

    always @(negedge clock) begin : mon_c
        exp_t e;
        if (reset && iv_c && ir_c) begin
            if (q_c.size() == 0) begin
                chk("unexpected_idx_c", idx_c, 32'hFFFF_FFFF);
            end else begin
                e = q_c.pop_front();
                chk("idx_c", idx_c, e.idx);
                chk("last_c", last_c, e.lst);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        lv_a = 1'b0; lv_b = 1'b0; lv_c = 1'b0;
        ir_a = 1'b1; ir_b = 1'b1; ir_c = 1'b1;
        cyc(2);

        // Reset state
        chk("rst_idx_valid", iv_a, 0);
        chk("rst_load_ready", lr_a, 0);
        chk("rst_idx_out", idx_a, 0);
        chk("rst_last", last_a, 0);
        chk("rst_done", done_a, 0);
        reset = 1'b1;
        cyc();
        chk("idle_load_ready", lr_a, 1);

        // 1: back-to-back emission 2,5,7 then done at N+4
        req_a = 8'b1010_0100; lv_a = 1'b1;
        push(0, 2, 0); push(0, 5, 0); push(0, 7, 1);
        cyc();
        lv_a = 1'b0;
        chk("latency_valid", iv_a, 1);
`ifdef OIT_REQ_ENC_MERGE_EN
        chk("emit_load_ready", lr_a, 1);
`else
        chk("emit_load_ready", lr_a, 0);
`endif
        cyc(3);
        chk("t1_done_n4", done_a, 1);
        chk("t1_valid_n4", iv_a, 0);
        cyc();
        chk("t1_done_pulse", done_a, 0);
        drain(10);

        // 2: stall holds idx_out=2
        ir_a = 1'b0; req_a = 8'b1010_0100; lv_a = 1'b1;
        push(0, 2, 0); push(0, 5, 0); push(0, 7, 1);
        cyc();
        lv_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_idx", idx_a, 2);
            chk("stall_valid", iv_a, 1);
            cyc();
        end
        ir_a = 1'b1;
        drain(10);

        // 3: empty load
        req_a = 8'h00; lv_a = 1'b1;
        cyc();
        lv_a = 1'b0;
        chk("empty_valid", iv_a, 0);
        chk("empty_load_ready", lr_a, 1);
        cyc(2);
        chk("empty_valid_late", iv_a, 0);
        chk("empty_done", done_a, 0);

        // 4: active-low lines and non-power-of-2 COUNT with top index
        req_b = 8'h7E; lv_b = 1'b1;
        push(1, 0, 0); push(1, 7, 1);
        req_c = 5'b10000; lv_c = 1'b1;
        push(2, 4, 1);
        cyc();
        lv_b = 1'b0; lv_c = 1'b0;
        drain(10);

        // 5: reset mid-emission after index 2 served
        req_a = 8'b1010_0100; lv_a = 1'b1;
        push(0, 2, 0);
        cyc();
        lv_a = 1'b0;
        cyc();
        reset = 1'b0;
        #1;
        chk("midrst_valid", iv_a, 0);
        chk("midrst_load_ready", lr_a, 0);
        chk("midrst_done", done_a, 0);
        cyc(2);
        reset = 1'b1;
        cyc();
        chk("postrst_load_ready", lr_a, 1);
        chk("postrst_done", done_a, 0);
        req_a = 8'b0001_0001; lv_a = 1'b1;
        push(0, 0, 0); push(0, 4, 1);
        cyc();
        lv_a = 1'b0;
        drain(10);

`ifdef OIT_REQ_ENC_MERGE_EN
        // 6: merge during a stall on index 5
        req_a = 8'b1010_0100; lv_a = 1'b1;
        push(0, 2, 0);
        cyc();
        lv_a = 1'b0;
        cyc();
        ir_a = 1'b0; req_a = 8'h01; lv_a = 1'b1;
        chk("merge_load_ready", lr_a, 1);
        cyc();
        lv_a = 1'b0;
        chk("merge_idx_hold", idx_a, 5);
        chk("merge_valid", iv_a, 1);
        chk("merge_last", last_a, 0);
        cyc();
        chk("merge_idx_hold2", idx_a, 5);
        push(0, 5, 0); push(0, 0, 0); push(0, 7, 1);
        ir_a = 1'b1;
        drain(10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
